uart_lsu_bridge: RTL and testbench
==================================

Name: uart_lsu_bridge

Overview:
- Parametrised memory-mapped UART front-end that sits between the core LSU request port (one_hot decode slot) and the existing uart serializer/deserializer.
- Replaces the single-byte transmit strobe and write-to-pop RX FIFO with:
  - a TX FIFO drained by a state machine;
  - a read-to-pop RX FIFO;
  - sticky overflow flags and a maskable interrupt.
- The uart core stays external; this block drives its transmit/tx_byte/baud/recv_ack inputs.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of two, >=2)
- RX_DEPTH, 16, RX FIFO entries (power of two, >=2)
- BAUD_RST, 16'd651, baud divisor value after reset

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  LSU request (already qualified by slot decode)
- we_i  in  1  write enable
- addr_i  in  4  word offset (LSU addr[5:2])
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- transmit_o  out  1  one-cycle transmit pulse to uart
- tx_byte_o  out  8  byte to transmit
- is_transmitting_i  in  1  uart TX busy
- received_i  in  1  uart byte-received level
- rx_byte_i  in  8  received byte
- recv_error_i  in  1  framing error of received byte
- recv_ack_o  out  1  received_i delayed one cycle
- baud_o  out  16  baud divisor
- irq_o  out  1  interrupt, level

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous, active-low, sampled on the clk_i rising edge.
- Reset values:
  - gnt_o is combinational.
  - rvalid_o=0, rdata_o=0, transmit_o=0, tx_byte_o=0, recv_ack_o=0, baud_o=BAUD_RST, irq_o=0.
  - FIFOs empty, flags clear, IRQ_EN=0, TX FSM in IDLE.
- Reset mid-frame: abandons FIFO contents. The uart core is not stopped; its in-flight byte completes unobserved.
- Handshake:
  - gnt_o = req_i in the same cycle.
  - rvalid_o is asserted exactly one cycle after each grant, for both reads and writes.
  - rdata_o is registered and valid only while rvalid_o=1; it is 0 for writes.
  - Back-to-back requests are allowed every cycle.
- Register map (by addr_i):
  - 0 TXDATA:
    - W: push wdata_i[7:0].
    - R: {16'b0, tx_level}.
  - 1 BAUD: R/W [15:0].
  - 2 RXDATA:
    - R: pops one entry, returns {22'b0, valid, err, data[7:0]}. valid=0 means the FIFO was empty; nothing is popped.
    - W: ignored.
  - 3 STATUS (R):
    - [31:16] rx_level, [15:8] tx_level.
    - [7] tx_busy (FSM not IDLE), [6] rx_ovf, [5] tx_ovf, [4] rx_full, [3] rx_empty, [2] tx_full, [1] tx_empty.
    - [0] loopback (0 if the feature is absent).
  - 4 IRQ_EN: R/W [2:0]. Enable bits: [0] rx_nonempty, [1] tx_empty, [2] overflow.
  - 5 IRQ_PEND:
    - R: raw {ovf, tx_empty, rx_nonempty}.
    - W: 1-to-clear rx_ovf (bit 3) and tx_ovf (bit 4).
  - 6 CTRL: R/W [0] loopback (only with the optional feature).
  - Other offsets read 0; writes to them are ignored.
- Level widths: tx_level/rx_level are $clog2(DEPTH)+1 bits, zero-extended.
- TX FIFO:
  - A push when full is dropped and sets tx_ovf (sticky).
  - A simultaneous push and FSM pop when full is accepted.
- TX FSM:
  - IDLE: if the FIFO is non-empty, pop into tx_byte_o and go to LAUNCH.
  - LAUNCH: transmit_o=1 for exactly one cycle, then go to WAIT_START.
  - WAIT_START: wait for is_transmitting_i=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for is_transmitting_i=0, then go to IDLE.
  - Minimum spacing between transmit_o pulses is 4 cycles plus the frame time.
- RX path:
  - recv_ack_o <= received_i.
  - A push happens on received_i & ~recv_ack_o with {recv_error_i, rx_byte_i}.
  - A push when full is dropped and sets rx_ovf, except when a CPU pop occurs the same cycle, in which case the push is accepted.
  - A pop when empty has no side effects.
- BAUD write: takes effect on baud_o the next cycle. Writing it while busy is allowed; the in-flight frame is undefined.
- Interrupt: irq_o is registered, equal to |(IRQ_EN & IRQ_PEND_raw). ovf = rx_ovf | tx_ovf.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: CTRL[0] is implemented. When it is set:
  - the TX FSM pops the byte into the RX FIFO (err=0) in one cycle and returns to IDLE;
  - transmit_o stays 0;
  - uart-side RX pushes are ignored.
- Undefined: CTRL reads 0, writes are ignored, STATUS[0]=0.

Decomposition:
- Package uart_lsu_pkg holds:
  - register offset localparams (REG_TXDATA..REG_CTRL);
  - STATUS and IRQ bit-index constants;
  - the tx_state_e enum {IDLE, LAUNCH, WAIT_START, WAIT_DONE}.
- One sub-module, sync_fifo #(WIDTH, DEPTH):
  - single clock, synchronous active-low reset;
  - push/pop/full/empty/level;
  - instantiated for TX (WIDTH 8) and RX (WIDTH 9).

Test Plan:
- Reset, then read BAUD, STATUS, IRQ_EN -> 651, 32'h0000_000A, 0; rvalid_o one cycle after each req_i.
- Write TXDATA 0x41, 0x42 with a uart model holding busy for 20 cycles -> two transmit_o pulses with tx_byte_o 0x41 then 0x42, no overlap, STATUS[1]=1 at the end.
- Push 17 bytes into TX_DEPTH=16 with the uart stalled busy:
  - the byte popped into the FSM frees one slot, so no drop occurs;
  - a 2nd burst to full plus one more byte -> tx_ovf=1;
  - IRQ_PEND write 0x10 clears it.
- Inject received_i pulses with 0x55 (err=0) and 0xAA (err=1) -> RXDATA reads 0x255, 0x3AA, then 0x000 (empty), with rx_level dropping 2, 1, 0.
- IRQ_EN=1, one received byte -> irq_o rises within 2 cycles of the received_i edge; the RXDATA pop drops it the cycle after rvalid_o.
- With UART_LOOPBACK_EN and CTRL=1, write TXDATA 0x5A -> transmit_o never pulses; RXDATA returns 0x25A.

Source files
------------

// File: rtl/uart_lsu_pkg.sv
// +----------------------------------------------------------------------+
// | uart_lsu_pkg : register map, status/irq bit indices, TX FSM states   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_lsu_pkg;

  localparam logic [3:0] REG_TXDATA   = 4'd0;
  localparam logic [3:0] REG_BAUD     = 4'd1;
  localparam logic [3:0] REG_RXDATA   = 4'd2;
  localparam logic [3:0] REG_STATUS   = 4'd3;
  localparam logic [3:0] REG_IRQ_EN   = 4'd4;
  localparam logic [3:0] REG_IRQ_PEND = 4'd5;
  localparam logic [3:0] REG_CTRL     = 4'd6;

  localparam int ST_LOOPBACK = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;
  localparam int ST_TX_BUSY  = 7;

  localparam int IRQ_RX_NONEMPTY = 0;
  localparam int IRQ_TX_EMPTY    = 1;
  localparam int IRQ_OVF         = 2;

  // Write-1-to-clear positions in IRQ_PEND
  localparam int PEND_CLR_RX_OVF = 3;
  localparam int PEND_CLR_TX_OVF = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock show-ahead FIFO, push accepted when full    |
// |             if a pop happens in the same cycle                       |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == C_DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_lsu_bridge.sv
// +----------------------------------------------------------------------+
// | uart_lsu_bridge : LSU-mapped UART front-end with TX/RX FIFOs, sticky |
// |                   overflow flags and maskable irq.                   |
// |                   Optional loopback: define UART_LOOPBACK_EN         |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_lsu_bridge #(
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter logic [15:0] BAUD_RST = 16'd651
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        transmit_o,
  output logic [7:0]  tx_byte_o,
  input  logic        is_transmitting_i,
  input  logic        received_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        recv_error_i,
  output logic        recv_ack_o,
  output logic [15:0] baud_o,
  output logic        irq_o
);
  import uart_lsu_pkg::*;

  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;

  logic             w_wr, w_rd, w_loopback, w_lb_push;
  logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop;
  logic [7:0]       w_tx_head;
  logic [TX_LW-1:0] w_tx_level;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
  logic [8:0]       w_rx_head, w_rx_wdata;
  logic [RX_LW-1:0] w_rx_level;
  logic [2:0]       w_irq_raw;
  logic [31:0]      w_rdata;
  logic             w_unused;
  tx_state_e        r_state, w_state_next;
  logic [15:0]      r_baud;
  logic [2:0]       r_irq_en;
  logic             r_tx_ovf, r_rx_ovf, r_rvalid, r_recv_ack, r_irq;
  logic [31:0]      r_rdata;
  logic [7:0]       r_tx_byte;

  assign w_wr       = req_i & we_i;
  assign w_rd       = req_i & ~we_i;
  assign gnt_o      = req_i;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign transmit_o = (r_state == LAUNCH);
  assign tx_byte_o  = r_tx_byte;
  assign recv_ack_o = r_recv_ack;
  assign baud_o     = r_baud;
  assign irq_o      = r_irq;
  assign w_unused   = ^wdata_i[31:16];

`ifdef UART_LOOPBACK_EN
  logic r_loopback;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                       r_loopback <= 1'b0;
    else if (w_wr && addr_i == REG_CTRL) r_loopback <= wdata_i[0];
  end
  assign w_loopback = r_loopback;
`else
  assign w_loopback = 1'b0;
`endif

  assign w_tx_push = w_wr & (addr_i == REG_TXDATA);
  assign w_tx_drop = w_tx_push & w_tx_full & ~w_tx_pop;

  // Uart-side bytes are ignored in loopback; only the FSM feeds RX then
  assign w_rx_push  = (received_i & ~r_recv_ack & ~w_loopback) | w_lb_push;
  assign w_rx_wdata = w_lb_push ? {1'b0, w_tx_head} : {recv_error_i, rx_byte_i};
  assign w_rx_pop   = w_rd & (addr_i == REG_RXDATA) & ~w_rx_empty;
  assign w_rx_drop  = w_rx_push & w_rx_full & ~w_rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_i), .rst_n(rst_ni), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_wdata(wdata_i[7:0]), .o_rdata(w_tx_head), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_level(w_tx_level)
  );

  sync_fifo #(.WIDTH(9), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_i), .rst_n(rst_ni), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_wdata(w_rx_wdata), .o_rdata(w_rx_head), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_level(w_rx_level)
  );

  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_lb_push    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop = 1'b1;
          if (w_loopback) w_lb_push    = 1'b1;
          else            w_state_next = LAUNCH;
        end
      end
      LAUNCH:     w_state_next = WAIT_START;
      WAIT_START: if (is_transmitting_i)  w_state_next = WAIT_DONE;
      WAIT_DONE:  if (!is_transmitting_i) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  assign w_irq_raw = {r_rx_ovf | r_tx_ovf, w_tx_empty, ~w_rx_empty};

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      REG_TXDATA:   w_rdata = 32'(w_tx_level);
      REG_BAUD:     w_rdata = {16'b0, r_baud};
      // Empty FIFO reads back all-zero rather than a stale entry
      REG_RXDATA:   w_rdata = {22'b0, ~w_rx_empty, w_rx_empty ? 9'b0 : w_rx_head};
      REG_STATUS:   w_rdata = {16'(w_rx_level), 8'(w_tx_level), r_state != IDLE,
                               r_rx_ovf, r_tx_ovf, w_rx_full, w_rx_empty,
                               w_tx_full, w_tx_empty, w_loopback};
      REG_IRQ_EN:   w_rdata = {29'b0, r_irq_en};
      REG_IRQ_PEND: w_rdata = {29'b0, w_irq_raw};
      REG_CTRL:     w_rdata = {31'b0, w_loopback};
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_recv_ack <= 1'b0;
      r_baud     <= BAUD_RST;
      r_irq_en   <= '0;
      r_tx_ovf   <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_tx_byte  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rvalid   <= req_i;
      r_rdata    <= w_rd ? w_rdata : '0;
      r_recv_ack <= received_i;
      r_irq      <= |(r_irq_en & w_irq_raw);
      if (w_wr && addr_i == REG_BAUD)   r_baud   <= wdata_i[15:0];
      if (w_wr && addr_i == REG_IRQ_EN) r_irq_en <= wdata_i[2:0];
      if (w_tx_pop)                     r_tx_byte <= w_tx_head;
      // A new overflow in the same cycle as a clear keeps the flag set
      if (w_wr && addr_i == REG_IRQ_PEND && wdata_i[PEND_CLR_TX_OVF]) r_tx_ovf <= 1'b0;
      if (w_wr && addr_i == REG_IRQ_PEND && wdata_i[PEND_CLR_RX_OVF]) r_rx_ovf <= 1'b0;
      if (w_tx_drop) r_tx_ovf <= 1'b1;
      if (w_rx_drop) r_rx_ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_lsu_bridge.sv
// +----------------------------------------------------------------------+
// | tb_uart_lsu_bridge : randomized self-checking bench with a queue     |
// |                      model of the register map and a uart model      |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_lsu_bridge;

  localparam logic [3:0] A_TX = 4'd0, A_BAUD = 4'd1, A_RX = 4'd2, A_STAT = 4'd3;
  localparam logic [3:0] A_IEN = 4'd4, A_IPEND = 4'd5, A_CTRL = 4'd6;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, transmit_o, recv_ack_o, irq_o;
  logic [31:0] rdata_o;
  logic [7:0]  tx_byte_o;
  logic [15:0] baud_o;
  logic        is_transmitting_i = 1'b0;
  logic        received_i = 1'b0;
  logic [7:0]  rx_byte_i = '0;
  logic        recv_error_i = 1'b0;

  always #5 clk = ~clk;

  uart_lsu_bridge dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .transmit_o(transmit_o), .tx_byte_o(tx_byte_o),
    .is_transmitting_i(is_transmitting_i), .received_i(received_i),
    .rx_byte_i(rx_byte_i), .recv_error_i(recv_error_i), .recv_ack_o(recv_ack_o),
    .baud_o(baud_o), .irq_o(irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] exp_tx[$];
  logic [8:0] m_rx[$];
  bit         m_rx_ovf = 0, m_tx_ovf = 0;
  logic [2:0] m_irq_en = '0;

  // Uart model control
  bit uart_stall = 0;
  bit frame_fix  = 0;
  bit u_active   = 0;
  int u_delay = 0, u_frame = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    #1 check("wr_gnt", {31'b0, gnt_o}, 1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    check("wr_rvalid", {31'b0, rvalid_o}, 1);
    check("wr_rdata", rdata_o, 0);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 check("rd_gnt", {31'b0, gnt_o}, 1);
    @(posedge clk); #1;
    req_i = 1'b0;
    check("rd_rvalid", {31'b0, rvalid_o}, 1);
    d = rdata_o;
  endtask

  task automatic rx_inject(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    rx_byte_i = b; recv_error_i = e; received_i = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 received_i = 1'b0;
    @(posedge clk); #1;
    if (m_rx.size() < DEPTH) m_rx.push_back({e, b});
    else                     m_rx_ovf = 1;
  endtask

  task automatic rd_rxdata_chk(input string tag);
    logic [31:0] d, e;
    bus_rd(A_RX, d);
    if (m_rx.size() == 0) e = 32'h0;
    else                  e = 32'h200 | 32'(m_rx.pop_front());
    check(tag, d, e);
  endtask

  task automatic status_rx_chk();
    logic [31:0] s;
    bus_rd(A_STAT, s);
    check("st_rx_level", {16'b0, s[31:16]}, m_rx.size());
    check("st_rx_empty", {31'b0, s[3]}, m_rx.size() == 0);
    check("st_rx_full", {31'b0, s[4]}, m_rx.size() == DEPTH);
    check("st_rx_ovf", {31'b0, s[6]}, m_rx_ovf);
    check("st_tx_ovf", {31'b0, s[5]}, m_tx_ovf);
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] s;
    bit done = 0;
    for (int i = 0; i < 1500 && !done; i++) begin
      bus_rd(A_STAT, s);
      if (s[1] && !s[7]) done = 1;
    end
    check(tag, {31'b0, done}, 1);
    check({tag, "_all_sent"}, exp_tx.size(), 0);
  endtask

  // Uart model: busy rises a few cycles after each transmit pulse, holds for a frame
  initial begin
    forever begin
      @(negedge clk);
      if (transmit_o) begin
        check("tx_overlap", {31'b0, u_active}, 0);
        if (exp_tx.size() == 0) check("tx_unexpected", {24'b0, tx_byte_o}, 32'hFFFF_FFFF);
        else                    check("tx_byte", {24'b0, tx_byte_o}, {24'b0, exp_tx.pop_front()});
        u_active = 1;
        u_delay  = $urandom_range(0, 2);
        u_frame  = frame_fix ? 20 : $urandom_range(4, 12);
      end else if (u_active) begin
        if (u_delay != 0)            u_delay--;
        else if (!is_transmitting_i) is_transmitting_i = 1'b1;
        else if (u_frame != 0)       u_frame--;
        else if (!uart_stall) begin
          is_transmitting_i = 1'b0;
          u_active = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [15:0] bd;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_baud", {16'b0, baud_o}, 651);
    check("rst_rvalid", {31'b0, rvalid_o}, 0);
    check("rst_transmit", {31'b0, transmit_o}, 0);
    check("rst_irq", {31'b0, irq_o}, 0);
    check("rst_tx_byte", {24'b0, tx_byte_o}, 0);
    check("rst_rdata", rdata_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    bus_rd(A_BAUD, d);  check("baud_rd", d, 651);
    bus_rd(A_STAT, d);  check("status_rst", d, 32'h0000_000A);
    bus_rd(A_IEN, d);   check("irq_en_rst", d, 0);

    // Two bytes, 20-cycle frames
    frame_fix = 1;
    bus_wr(A_TX, 32'h41); exp_tx.push_back(8'h41);
    bus_wr(A_TX, 32'h42); exp_tx.push_back(8'h42);
    wait_tx_idle("two_bytes");
    bus_rd(A_STAT, d); check("two_bytes_tx_empty", {31'b0, d[1]}, 1);
    frame_fix = 0;

    // 17 back-to-back pushes with the uart stalled busy
    uart_stall = 1;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      @(posedge clk); #1;
      if (i > 0) check("burst_rvalid", {31'b0, rvalid_o}, 1);
      req_i = 1'b1; we_i = 1'b1; addr_i = A_TX; wdata_i = {24'b0, b};
      exp_tx.push_back(b);
    end
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    check("burst_rvalid", {31'b0, rvalid_o}, 1);
    bus_rd(A_STAT, d);
    check("burst_tx_level", {24'b0, d[15:8]}, 16);
    check("burst_tx_full", {31'b0, d[2]}, 1);
    check("burst_no_ovf", {31'b0, d[5]}, 0);
    bus_wr(A_TX, 32'h99); m_tx_ovf = 1;
    bus_rd(A_IPEND, d);  check("ipend_ovf", d, 32'h4);
    status_rx_chk();
    bus_wr(A_IPEND, 32'h10); m_tx_ovf = 0;
    status_rx_chk();
    uart_stall = 0;
    wait_tx_idle("burst_drain");

    // Two received bytes, one with framing error
    rx_inject(8'h55, 1'b0);
    rx_inject(8'hAA, 1'b1);
    status_rx_chk(); rd_rxdata_chk("rx_first");
    status_rx_chk(); rd_rxdata_chk("rx_second");
    status_rx_chk(); rd_rxdata_chk("rx_empty");

    // Interrupt timing around one received byte
    bus_wr(A_IEN, 32'h1); m_irq_en = 3'b001;
    @(posedge clk); #1;
    rx_byte_i = 8'h33; recv_error_i = 1'b0; received_i = 1'b1;
    @(posedge clk); #1 check("irq_early", {31'b0, irq_o}, 0);
    @(posedge clk); #1 check("irq_rise", {31'b0, irq_o}, 1);
    received_i = 1'b0;
    m_rx.push_back(9'h033);
    rd_rxdata_chk("irq_rx_data");
    check("irq_hold", {31'b0, irq_o}, 1);
    @(posedge clk); #1 check("irq_fall", {31'b0, irq_o}, 0);

`ifdef UART_LOOPBACK_EN
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_STAT, d); check("lb_status", {31'b0, d[0]}, 1);
    bus_wr(A_TX, 32'h5A);
    m_rx.push_back(9'h05A);
    repeat (4) @(posedge clk);
    rd_rxdata_chk("lb_rx");
    bus_wr(A_CTRL, 32'h0);
`else
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_CTRL, d); check("ctrl_absent", d, 0);
    bus_rd(A_STAT, d); check("lb_absent", {31'b0, d[0]}, 0);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 6))
        0: if (exp_tx.size() < 8) begin
             b = 8'($urandom);
             bus_wr(A_TX, {24'b0, b});
             exp_tx.push_back(b);
           end
        1, 2: rx_inject(8'($urandom), 1'($urandom));
        3: rd_rxdata_chk("rnd_rx");
        4: status_rx_chk();
        5: begin
             bd = 16'($urandom);
             bus_wr(A_BAUD, {16'($urandom), bd});
             check("rnd_baud_o", {16'b0, baud_o}, {16'b0, bd});
             bus_rd(A_BAUD, d); check("rnd_baud_rd", d, {16'b0, bd});
           end
        default: begin
             m_irq_en = 3'($urandom) & 3'b101;
             bus_wr(A_IEN, {29'b0, m_irq_en});
             if ($urandom_range(0, 1) == 1) begin
               bus_wr(A_IPEND, 32'h08); m_rx_ovf = 0;
             end
           end
      endcase
      repeat (2) @(posedge clk);
      #1 check("rnd_irq", {31'b0, irq_o},
               {31'b0, (m_irq_en[0] & (m_rx.size() != 0)) |
                       (m_irq_en[2] & (m_rx_ovf | m_tx_ovf))});
    end
    bus_wr(A_IEN, 32'h0);
    wait_tx_idle("final_drain");
    status_rx_chk();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
